// File: rtl/note_display_pkg.sv
// Shared types, glyph bitmaps and note decoding for the note display controller.
// Bitmaps are 12x12, row-major, MSB = top-left pixel.
package note_display_pkg;

  localparam int GLYPH_DIM  = 12;
  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;

  typedef logic [143:0] glyph_t;

  localparam logic [3:0] NOTE_A  = 4'd1;
  localparam logic [3:0] NOTE_AS = 4'd2;
  localparam logic [3:0] NOTE_B  = 4'd3;
  localparam logic [3:0] NOTE_C  = 4'd4;
  localparam logic [3:0] NOTE_CS = 4'd5;
  localparam logic [3:0] NOTE_D  = 4'd6;
  localparam logic [3:0] NOTE_DS = 4'd7;
  localparam logic [3:0] NOTE_E  = 4'd8;
  localparam logic [3:0] NOTE_F  = 4'd9;
  localparam logic [3:0] NOTE_FS = 4'd10;
  localparam logic [3:0] NOTE_G  = 4'd11;
  localparam logic [3:0] NOTE_GS = 4'd12;

  localparam glyph_t GLYPH_A     = 144'h060_0F0_198_30C_30C_30C_7FE_7FE_C03_C03_C03_000;
  localparam glyph_t GLYPH_B     = 144'h7F8_60C_60C_60C_7F8_7F8_60C_606_606_60C_7F8_000;
  localparam glyph_t GLYPH_C     = 144'h1FC_306_600_600_600_600_600_600_600_306_1FC_000;
  localparam glyph_t GLYPH_D     = 144'h7F0_618_60C_606_606_606_606_606_60C_618_7F0_000;
  localparam glyph_t GLYPH_E     = 144'h7FE_600_600_600_7FC_7FC_600_600_600_600_7FE_000;
  localparam glyph_t GLYPH_F     = 144'h7FE_600_600_600_7FC_7FC_600_600_600_600_600_000;
  localparam glyph_t GLYPH_G     = 144'h1FC_306_600_600_600_63E_606_606_606_306_1FC_000;
  localparam glyph_t GLYPH_SHARP = 144'h198_198_7FE_7FE_198_198_198_7FE_7FE_198_198_000;
  localparam glyph_t GLYPH_D1    = 144'h060_0E0_1E0_060_060_060_060_060_060_060_1F8_000;
  localparam glyph_t GLYPH_D2    = 144'h1F8_30C_00C_00C_018_030_060_0C0_180_300_3FC_000;
  localparam glyph_t GLYPH_D3    = 144'h1F8_30C_00C_00C_078_078_00C_00C_00C_30C_1F8_000;
  localparam glyph_t GLYPH_D4    = 144'h018_038_078_0D8_198_318_3FE_3FE_018_018_018_000;

  typedef enum logic [2:0] {IDLE, CLEAR, ERASE, SHARP, LETTER, OCT, FIN} state_t;

  typedef struct packed {
    glyph_t glyph;
    logic   is_sharp;
    logic   valid;
  } note_info_t;

  function automatic note_info_t decode_note(input logic [3:0] note);
    note_info_t info;
    info.glyph    = GLYPH_A;
    info.is_sharp = 1'b0;
    info.valid    = 1'b1;
    case (note)
      NOTE_A:  info.glyph = GLYPH_A;
      NOTE_AS: begin info.glyph = GLYPH_A; info.is_sharp = 1'b1; end
      NOTE_B:  info.glyph = GLYPH_B;
      NOTE_C:  info.glyph = GLYPH_C;
      NOTE_CS: begin info.glyph = GLYPH_C; info.is_sharp = 1'b1; end
      NOTE_D:  info.glyph = GLYPH_D;
      NOTE_DS: begin info.glyph = GLYPH_D; info.is_sharp = 1'b1; end
      NOTE_E:  info.glyph = GLYPH_E;
      NOTE_F:  info.glyph = GLYPH_F;
      NOTE_FS: begin info.glyph = GLYPH_F; info.is_sharp = 1'b1; end
      NOTE_G:  info.glyph = GLYPH_G;
      NOTE_GS: begin info.glyph = GLYPH_G; info.is_sharp = 1'b1; end
      default: info.valid = 1'b0;
    endcase
    return info;
  endfunction

  function automatic glyph_t digit_glyph(input logic [1:0] octave);
    case (octave)
      2'd0:    return GLYPH_D1;
      2'd1:    return GLYPH_D2;
      2'd2:    return GLYPH_D3;
      default: return GLYPH_D4;
    endcase
  endfunction

endpackage

// File: rtl/note_display_ctrl_glyph_raster.sv
// Walks a 12x12 bitmap (or a solid 36x12 erase block) and emits one registered pixel per cycle.
// First pixel is registered on the edge where start is sampled; last flags the final pixel being registered.
module glyph_raster
  import note_display_pkg::*;
#(
  parameter logic [2:0] FG = 3'b100,
  parameter logic [2:0] BG = 3'b000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [143:0] bitmap,
  input  logic [7:0]   org_x,
  input  logic [6:0]   org_y,
  input  logic         wide,
  output logic [7:0]   x,
  output logic [6:0]   y,
  output logic [2:0]   colour,
  output logic         we,
  output logic         active,
  output logic         last
);

  logic [5:0] col, cur_col, last_col;
  logic [3:0] row, cur_row;
  logic [7:0] bit_idx;
  logic       emit, pix_on;

  always_comb begin
    emit     = start | active;
    cur_col  = start ? 6'd0 : col;
    cur_row  = start ? 4'd0 : row;
    last_col = wide ? 6'd35 : 6'(GLYPH_DIM - 1);
    last     = emit && (cur_col == last_col) && (cur_row == 4'(GLYPH_DIM - 1));
    bit_idx  = 8'd143 - (8'(cur_row) * 8'(GLYPH_DIM) + 8'(cur_col));
    pix_on   = wide || bitmap[bit_idx];
  end

  // NOTE: sequential state uses <= so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      col    <= '0;
      row    <= '0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      we     <= 1'b0;
    end else if (emit) begin
      x      <= org_x + 8'(cur_col);
      y      <= org_y + 7'(cur_row);
      colour <= (pix_on && !wide) ? FG : BG;
      we     <= pix_on;
      if (last) begin
        active <= 1'b0;
        col    <= '0;
        row    <= '0;
      end else begin
        active <= 1'b1;
        if (cur_col == last_col) begin
          col <= '0;
          row <= cur_row + 4'd1;
        end else begin
          col <= cur_col + 6'd1;
          row <= cur_row;
        end
      end
    end else begin
      we <= 1'b0;
    end
  end

endmodule

// File: rtl/note_display_ctrl.sv
// Note display scheduler: erase slot, draw sharp/letter/octave glyphs, and (with NOTE_CLEAR_EN)
// full-screen clears, feeding the VGA pixel write port one pixel per cycle.
module note_display_ctrl
  import note_display_pkg::*;
#(
  parameter int         X_ORIGIN   = 8,
  parameter int         Y_ORIGIN   = 4,
  parameter int         SLOT_PITCH = 14,
  parameter int         NUM_SLOTS  = 8,
  parameter logic [2:0] FG_COLOUR  = 3'b100,
  parameter logic [2:0] BG_COLOUR  = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_note,
  input  logic [1:0] req_octave,
  input  logic [2:0] req_slot,
  input  logic       clr_req,
  output logic       busy,
  output logic       done,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       writeEn
);

  state_t       state, state_nxt;
  logic [3:0]   note_q;
  logic [1:0]   oct_q;
  logic [2:0]   slot_q, slot_c;
  note_info_t   info;
  logic [7:0]   sx, r_xoff, r_x;
  logic [6:0]   sy, r_y;
  logic [143:0] r_bitmap;
  logic [2:0]   r_colour;
  logic         r_wide, r_we, r_active, r_last, drawing, clr_go;

  assign info   = decode_note(note_q);
  assign slot_c = (int'(req_slot) >= NUM_SLOTS) ? 3'(NUM_SLOTS - 1) : req_slot;
  assign sx     = 8'(X_ORIGIN);
  assign sy     = 7'(Y_ORIGIN) + 7'(int'(slot_q) * SLOT_PITCH);

`ifdef NOTE_CLEAR_EN
  logic [7:0] cx, clr_x;
  logic [6:0] cy, clr_y;
  logic       clr_pend, clr_we, clr_last;

  assign clr_go    = clr_pend | clr_req;
  assign clr_last  = (cx == 8'(SCREEN_W - 1)) && (cy == 7'(SCREEN_H - 1));
  assign req_ready = (state == IDLE) && !clr_pend && !clr_req;
  assign busy      = (state != IDLE) || clr_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_pend <= 1'b0;
      cx       <= '0;
      cy       <= '0;
      clr_x    <= '0;
      clr_y    <= '0;
      clr_we   <= 1'b0;
    end else begin
      clr_pend <= (state_nxt == CLEAR && state != CLEAR) ? 1'b0 : (clr_pend | clr_req);
      if (state == CLEAR) begin
        clr_x  <= cx;
        clr_y  <= cy;
        clr_we <= 1'b1;
        if (cx == 8'(SCREEN_W - 1)) begin
          cx <= '0;
          cy <= clr_last ? 7'd0 : cy + 7'd1;
        end else begin
          cx <= cx + 8'd1;
        end
      end else begin
        clr_we <= 1'b0;
        cx     <= '0;
        cy     <= '0;
      end
    end
  end

  // Both pixel sources are registered; only one is ever writing at a time.
  assign x_out   = clr_we ? clr_x : r_x;
  assign y_out   = clr_we ? clr_y : r_y;
  assign colour  = clr_we ? BG_COLOUR : r_colour;
  assign writeEn = clr_we | r_we;
`else
  logic unused_clr;
  assign unused_clr = clr_req;
  assign clr_go     = 1'b0;
  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign x_out      = r_x;
  assign y_out      = r_y;
  assign colour     = r_colour;
  assign writeEn    = r_we;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      done   <= 1'b0;
      note_q <= '0;
      oct_q  <= '0;
      slot_q <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state == FIN);
      if (req_valid && req_ready && !clr_go) begin
        note_q <= req_note;
        oct_q  <= req_octave;
        slot_q <= slot_c;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    r_bitmap  = '0;
    r_xoff    = '0;
    r_wide    = 1'b0;
    drawing   = 1'b1;
    case (state)
      IDLE: begin
        drawing = 1'b0;
        if (clr_go)                      state_nxt = CLEAR;
        else if (req_valid && req_ready) state_nxt = ERASE;
      end
`ifdef NOTE_CLEAR_EN
      CLEAR: begin
        drawing = 1'b0;
        if (clr_last) state_nxt = FIN;
      end
`endif
      ERASE: begin
        r_wide = 1'b1;
        if (r_last) begin
          if (!info.valid)        state_nxt = FIN;
          else if (info.is_sharp) state_nxt = SHARP;
          else                    state_nxt = LETTER;
        end
      end
      SHARP: begin
        r_bitmap = GLYPH_SHARP;
        if (r_last) state_nxt = LETTER;
      end
      LETTER: begin
        r_bitmap = info.glyph;
        r_xoff   = 8'(GLYPH_DIM);
        if (r_last) state_nxt = OCT;
      end
      OCT: begin
        r_bitmap = digit_glyph(oct_q);
        r_xoff   = 8'(2 * GLYPH_DIM);
        if (r_last) state_nxt = FIN;
      end
      FIN: begin
        drawing   = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        drawing   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // A new phase starts in the first cycle the raster is idle, keeping pixels back-to-back.
  glyph_raster #(.FG(FG_COLOUR), .BG(BG_COLOUR)) u_raster (
    .clk    (clk),
    .reset  (reset),
    .start  (drawing && !r_active),
    .bitmap (r_bitmap),
    .org_x  (sx + r_xoff),
    .org_y  (sy),
    .wide   (r_wide),
    .x      (r_x),
    .y      (r_y),
    .colour (r_colour),
    .we     (r_we),
    .active (r_active),
    .last   (r_last)
  );

endmodule

// File: tb/tb_note_display_ctrl.sv
// Self-checking bench for note_display_ctrl: a per-cycle expected pixel stream built from the
// display rules is compared against the DUT outputs every cycle. Adapts to NOTE_CLEAR_EN.
module tb_note_display_ctrl;
  import note_display_pkg::*;

  localparam logic [7:0] M_X0    = 8'd8;
  localparam int         M_Y0    = 4;
  localparam int         M_PITCH = 14;
  localparam logic [2:0] M_FG    = 3'b100;
  localparam logic [2:0] M_BG    = 3'b000;

  logic       clk = 1'b0, reset = 1'b1, req_valid = 1'b0, clr_req = 1'b0;
  logic [3:0] req_note = '0;
  logic [1:0] req_octave = '0;
  logic [2:0] req_slot = '0;
  logic       req_ready, busy, done, writeEn;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;

  always #5 clk = ~clk;

  note_display_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_note(req_note), .req_octave(req_octave), .req_slot(req_slot), .clr_req(clr_req),
    .busy(busy), .done(done), .x_out(x_out), .y_out(y_out), .colour(colour), .writeEn(writeEn)
  );

  typedef struct {
    bit         we;
    bit         done;
    bit         chk_px;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
  } exp_t;

  exp_t exp_q[$];
  exp_t stage[$];
  exp_t mon_e;
  int   vectors = 0, miscompares = 0;
  bit   mon_en = 1'b0;
  int   letter_idx[13] = '{0, 0, 0, 1, 2, 2, 3, 3, 4, 5, 5, 6, 6};
  bit   sharp_tab[13]  = '{0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(bit we, bit dn, bit chk, logic [7:0] x, logic [6:0] y, logic [2:0] c);
    exp_t e;
    e.we = we; e.done = dn; e.chk_px = chk; e.x = x; e.y = y; e.col = c;
    return e;
  endfunction

  function automatic glyph_t letter_glyph(int i);
    case (i)
      0: return GLYPH_A;
      1: return GLYPH_B;
      2: return GLYPH_C;
      3: return GLYPH_D;
      4: return GLYPH_E;
      5: return GLYPH_F;
      default: return GLYPH_G;
    endcase
  endfunction

  function automatic glyph_t octave_glyph(int o);
    case (o)
      0: return GLYPH_D1;
      1: return GLYPH_D2;
      2: return GLYPH_D3;
      default: return GLYPH_D4;
    endcase
  endfunction

  task automatic draw(input glyph_t g, input logic [7:0] ox, input logic [6:0] oy);
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 12; c++) begin
        bit b = g[143 - (r * 12 + c)];
        stage.push_back(mk(b, 0, 1, ox + 8'(c), oy + 7'(r), b ? M_FG : M_BG));
      end
  endtask

  // Expected cycles after the transfer edge: one quiet cycle, erase, glyphs, then done.
  task automatic build_req(input int note, input int oct, input int slot);
    logic [7:0] sx;
    logic [6:0] sy;
    stage.delete();
    stage.push_back(mk(0, 0, 0, 0, 0, 0));
    if (slot > 7) slot = 7;
    sx = M_X0;
    sy = 7'(M_Y0 + slot * M_PITCH);
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 36; c++)
        stage.push_back(mk(1, 0, 1, sx + 8'(c), sy + 7'(r), M_BG));
    if (note >= 1 && note <= 12) begin
      if (sharp_tab[note]) draw(GLYPH_SHARP, sx, sy);
      draw(letter_glyph(letter_idx[note]), sx + 8'd12, sy);
      draw(octave_glyph(oct), sx + 8'd24, sy);
    end
    stage.push_back(mk(0, 1, 0, 0, 0, 0));
  endtask

  task automatic build_clear();
    stage.delete();
    stage.push_back(mk(0, 0, 0, 0, 0, 0));
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        stage.push_back(mk(1, 0, 1, 8'(x), 7'(y), M_BG));
    stage.push_back(mk(0, 1, 0, 0, 0, 0));
  endtask

  task automatic commit();
    foreach (stage[i]) exp_q.push_back(stage[i]);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("writeEn", writeEn, mon_e.we);
        check("done", done, mon_e.done);
        if (mon_e.chk_px) begin
          check("x_out", x_out, mon_e.x);
          check("y_out", y_out, mon_e.y);
          check("colour", colour, mon_e.col);
        end
        if (!mon_e.done) begin
          check("busy_active", busy, 1);
          check("req_ready_active", req_ready, 0);
        end
      end else begin
        check("writeEn_idle", writeEn, 0);
        check("done_idle", done, 0);
        check("busy_idle", busy, 0);
`ifdef NOTE_CLEAR_EN
        check("req_ready_idle", req_ready, !clr_req);
`else
        check("req_ready_idle", req_ready, 1);
`endif
      end
    end
  end

  task automatic wait_drain();
    int i;
    for (i = 0; i < 25000 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic send_req(input int note, input int oct, input int slot, input bit with_clr);
    bit got = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_note = 4'(note); req_octave = 2'(oct); req_slot = 3'(slot);
    clr_req = with_clr;
    for (int i = 0; i < 25000 && !got; i++) begin
      @(negedge clk);
      got = req_ready;
      @(posedge clk); #1;
      clr_req = 1'b0;
`ifdef NOTE_CLEAR_EN
      if (with_clr && i == 0 && !got) begin build_clear(); commit(); end
`endif
    end
    if (!got) check("req_accept_timeout", 0, 1);
    req_valid  = 1'b0;
    req_note   = ~req_note;
    req_octave = ~req_octave;
    req_slot   = ~req_slot;
    if (got) begin build_req(note, oct, slot); commit(); end
  endtask

  task automatic pulse_clr();
    #1 clr_req = 1'b1;
    @(posedge clk); #1 clr_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_x_out", x_out, 0);
    check("rst_y_out", y_out, 0);
    check("rst_colour", colour, 0);
    check("rst_writeEn", writeEn, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    mon_en = 1'b1;

    // Hand-computed anchors for the model itself.
    build_req(2, 1, 0);
    check("pin_len_sharp", stage.size(), 866);
    check("pin_erase0_x", stage[1].x, 8);
    check("pin_erase0_y", stage[1].y, 4);
    check("pin_erase_last_x", stage[432].x, 43);
    check("pin_erase_last_y", stage[432].y, 15);
    check("pin_sharp0_x", stage[433].x, 8);
    check("pin_letter0_x", stage[577].x, 20);
    check("pin_letter0_we", stage[577].we, 0);
    check("pin_letter5_we", stage[582].we, 1);
    check("pin_letter5_col", stage[582].col, 3'b100);
    check("pin_digit0_x", stage[721].x, 32);
    check("pin_digit_last_x", stage[864].x, 43);
    check("pin_done_pos", stage[865].done, 1);
    build_req(3, 0, 7);
    check("pin_len_natural", stage.size(), 722);
    check("pin_slot7_y", stage[1].y, 102);
    build_req(0, 0, 0);
    check("pin_len_invalid", stage.size(), 434);
    build_clear();
    check("pin_len_clear", stage.size(), 19202);
    check("pin_clear_last_x", stage[19200].x, 159);
    check("pin_clear_last_y", stage[19200].y, 119);

    send_req(2, 1, 0, 0);  wait_drain();
    send_req(3, 0, 7, 0);  wait_drain();
    send_req(0, 2, 3, 0);  wait_drain();
    send_req(13, 1, 4, 0); wait_drain();
    send_req(12, 3, 5, 0); wait_drain();
    send_req(4, 2, 3, 0);  wait_drain();

    // Clear pulse while the letter glyph is being drawn.
    send_req(10, 2, 6, 0);
    repeat (600) @(posedge clk);
    pulse_clr();
`ifdef NOTE_CLEAR_EN
    build_clear(); commit();
`endif
    wait_drain();

    // Clear and request together in IDLE.
    send_req(8, 3, 2, 1); wait_drain();

    // Reset in the middle of ERASE with a clear pending.
    send_req(5, 0, 1, 0);
    repeat (100) @(posedge clk);
    pulse_clr();
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_writeEn", writeEn, 0);
    check("abort_busy", busy, 0);
    check("abort_req_ready", req_ready, 1);
    repeat (40) @(negedge clk);

    send_req(6, 3, 1, 0); wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
